// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Target side of the CPU memory bus. Serves a word-addressed RAM with a
//   registered, read-first port (1-cycle read latency), plus a 4-word MMIO
//   window: GPIO output, free-running 32-bit cycle counter (lo/hi with a
//   hi-latch for coherent reads) and an optional 8N1 UART transmitter.
//
//   Optional feature macro: MEM_UART_EN
//     defined   -> UART FSM present at MMIO_BASE+3
//     undefined -> no UART logic, uart_tx_o tied high, +3 reads 0
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   mem_addr_i  word address from the core
//   mem_data_i  write data from the core
//   mem_we      write enable, sampled at the rising edge
//   mem_data_o  registered read data (read every cycle)
//   gpio_o      GPIO output register
//   uart_tx_o   serial TX line, idles high
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int          RAM_SIZE_LOG = 10,
    parameter logic [15:0] MMIO_BASE    = 16'hFFF0,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_data_i,
    input  logic        mem_we,
    output logic [15:0] mem_data_o,
    output logic [15:0] gpio_o,
    output logic        uart_tx_o
);

    localparam int RAM_DEPTH = 2 ** RAM_SIZE_LOG;

    logic [15:0]             r_ram [0:RAM_DEPTH-1];
    logic [15:0]             r_mem_data;
    logic [15:0]             r_gpio;
    logic [31:0]             r_cnt;
    logic [15:0]             r_cnt_hi;

    logic                    w_is_ram;
    logic                    w_is_mmio;
    logic [15:0]             w_mmio_off;
    logic [RAM_SIZE_LOG-1:0] w_ram_idx;
    logic [15:0]             w_rd_val;
    logic                    w_uart_busy;
    logic                    w_uart_tx;

    // RAM region never aliases: every address bit above the index must be 0.
    assign w_is_ram   = ((mem_addr_i >> RAM_SIZE_LOG) == 16'd0);
    assign w_ram_idx  = mem_addr_i[RAM_SIZE_LOG-1:0];
    assign w_mmio_off = mem_addr_i - MMIO_BASE;
    assign w_is_mmio  = !w_is_ram && (w_mmio_off < 16'd4);

    // NOTE: the RAM array has no reset; clearing it would forbid block-RAM
    // mapping, and software must not rely on power-up contents anyway.
    always_ff @(posedge clk_i) begin
        if (mem_we && w_is_ram) begin
            r_ram[w_ram_idx] <= mem_data_i;
        end
    end

    // NOTE: always_comb assigns every output a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rd_val = 16'd0;
        if (w_is_ram) begin
            w_rd_val = r_ram[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_mmio_off[1:0])
                2'd0:    w_rd_val = r_gpio;
                2'd1:    w_rd_val = r_cnt[15:0];
                2'd2:    w_rd_val = r_cnt_hi;
                default: w_rd_val = {15'd0, w_uart_busy};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes the read-first RAM return
    // the old word and the hi-latch capture the pre-increment counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_data <= 16'd0;
            r_gpio     <= 16'd0;
            r_cnt      <= 32'd0;
            r_cnt_hi   <= 16'd0;
        end else begin
            r_mem_data <= w_rd_val;
            r_cnt      <= r_cnt + 32'd1;
            if (mem_we && w_is_mmio && (w_mmio_off[1:0] == 2'd0)) begin
                r_gpio <= mem_data_i;
            end
            // Reading CNT_LO freezes the upper half so a following CNT_HI
            // read is coherent with the low half already returned.
            if (w_is_mmio && (w_mmio_off[1:0] == 2'd1)) begin
                r_cnt_hi <= r_cnt[31:16];
            end
        end
    end

`ifdef MEM_UART_EN
    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam int             TICK_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

    uart_state_t       r_state, w_state_nxt;
    logic [TICK_W-1:0] r_tick,  w_tick_nxt;
    logic [2:0]        r_bit,   w_bit_nxt;
    logic [7:0]        r_byte,  w_byte_nxt;
    logic              w_tick_done;
    logic              w_uart_wr;

    assign w_uart_wr = mem_we && w_is_mmio && (w_mmio_off[1:0] == 2'd3);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= UART_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // Each non-idle state lasts CLKS_PER_BIT clocks; r_tick counts them.
    // A write arriving while not idle is simply not looked at.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_uart_tx   = 1'b1;
        w_tick_done = (r_tick == TICK_LAST);
        case (r_state)
            UART_IDLE: begin
                if (w_uart_wr) begin
                    w_byte_nxt  = mem_data_i[7:0];
                    w_tick_nxt  = '0;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                w_uart_tx = 1'b0;
                if (w_tick_done) begin
                    w_tick_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = UART_DATA;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            UART_DATA: begin
                w_uart_tx = r_byte[r_bit];
                if (w_tick_done) begin
                    w_tick_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            UART_STOP: begin
                w_uart_tx = 1'b1;
                if (w_tick_done) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = UART_IDLE;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
            end
        endcase
    end

    assign w_uart_busy = (r_state != UART_IDLE);
`else
    assign w_uart_busy = 1'b0;
    assign w_uart_tx   = 1'b1;
`endif

    assign mem_data_o = r_mem_data;
    assign gpio_o     = r_gpio;
    assign uart_tx_o  = w_uart_tx;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target side of the CPU memory bus: answers the core's address/data/write-enable with a word-addressed synchronous RAM and a small memory-mapped I/O window.
- Registered, read-first memory with 1-cycle read latency, matching the core's fetch/load timing.
- The MMIO window provides GPIO output, a free-running 32-bit cycle counter, and an optional UART transmitter.

Parameters:
RAM_SIZE_LOG, 10, log2 of RAM depth in 16-bit words
MMIO_BASE, 16'hFFF0, first address of the 4-word MMIO window
CLKS_PER_BIT, 16, UART bit period in clocks (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
mem_addr_i  in  16  word address from the core
mem_data_i  in  16  write data from the core
mem_we  in  1  write enable, sampled at the rising edge
mem_data_o  out  16  registered read data
gpio_o  out  16  GPIO output register
uart_tx_o  out  1  serial TX line, idles high

Behaviour:
- Reset (rst_i low, async): mem_data_o=0, gpio_o=0, counter=0, hi-latch=0, uart_tx_o=1, UART state IDLE. RAM contents are not cleared.
- Every edge: mem_data_o <= read value of mem_addr_i. Latency is exactly 1 cycle. There is no enable; a read occurs every cycle.
- Read-first: if mem_we=1 and the read address equals the write address in the same cycle, mem_data_o returns the OLD word.
- Region decode:
  - RAM: mem_addr_i < 2**RAM_SIZE_LOG; index = mem_addr_i[RAM_SIZE_LOG-1:0].
  - MMIO: MMIO_BASE..MMIO_BASE+3.
  - Any other address: reads 0, writes ignored. RAM never aliases.
- MMIO map:
  - +0 GPIO: RW; a write updates gpio_o on the same edge.
  - +1 CNT_LO: RO. Reading returns counter[15:0] and latches counter[31:16] into hi-latch on the same edge.
  - +2 CNT_HI: RO; returns hi-latch.
  - +3 UART: a write starts TX when idle; a write while busy is dropped. A read returns {15'b0, busy}.
  - Writes to RO registers are ignored.
- Counter: 32-bit; increments every cycle after reset, including reset release + 1; wraps from FFFF_FFFF to 0.
- UART FSM (8N1, LSB first):
  - IDLE: tx=1, busy=0. A write to +3 captures mem_data_i[7:0]; go to START. Upper bits are ignored.
  - START: tx=0 for CLKS_PER_BIT clocks; go to DATA.
  - DATA: 8 bits, CLKS_PER_BIT each, bit index 0..7; go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks; go to IDLE.
  - busy=1 in START/DATA/STOP. busy reads 1 on the cycle after the accepting write.
  - A frame occupies 10*CLKS_PER_BIT clocks from the edge after the write.
  - Back-to-back: a write in the last STOP cycle is dropped; software polls busy.
- Reset mid-frame: uart_tx_o goes high immediately, the FSM returns to IDLE, and the frame is lost.
- Simultaneous events: a write to +3 and a read of +3 in the same cycle return busy=0 (pre-write value), and the write is accepted.

Optional Feature:
MEM_UART_EN:
- Defined: the UART FSM and register +3 are present as above.
- Undefined:
  - No UART logic is synthesized.
  - uart_tx_o is constant 1.
  - +3 reads 0 and writes are ignored.
  - The rest of the behaviour is unchanged.

Test Plan:
- Reset low, then release; read address 0 after writing 16'hA5A5 there -> mem_data_o = 16'hA5A5 exactly 1 cycle after the address is presented; reset values all as listed.
- Same-cycle write 16'h1234 to address 5 (old value 16'h0BEE) with the read of address 5 -> mem_data_o=16'h0BEE; the next read returns 16'h1234.
- Write 16'hFFFF to address 16'h0400 with RAM_SIZE_LOG=10, then read it -> 0; address 0 is unchanged; write 16'h00C3 to FFF0 -> gpio_o=16'h00C3 the next cycle.
- Counter preloaded by running 2**16+3 cycles, then read FFF1 and FFF2 -> CNT_LO=value at the read edge, CNT_HI=16'h0001; counter wrap is checked via force at FFFF_FFFF -> 0.
- MEM_UART_EN defined, CLKS_PER_BIT=4:
  - Write 16'h0155 to FFF3 -> tx low for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks.
  - busy=1 throughout, 0 after 40 clocks.
  - A second write mid-frame is ignored.
- Assert reset at clock 12 of a frame -> uart_tx_o=1 immediately, busy=0 after release, gpio_o=0; MEM_UART_EN undefined -> FFF3 reads 0 and uart_tx_o stays 1.
